// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the two-manager SRAM data-port arbiter
// Contents: resp_tag_t (per-transaction response tag), MGR0/MGR1 manager indices.
package sram_arb_pkg;

    typedef struct packed {
        logic id;
        logic we;
    } resp_tag_t;

    localparam logic MGR0 = 1'b0;
    localparam logic MGR1 = 1'b1;

endpackage

// File: rtl/sram_d_arbiter_resp_tag_fifo.sv
// resp_tag_fifo: synchronous FIFO of response tags, one entry per accepted transaction
// Ports: clk_i/rst_i (sync, active-high), push_i/tag_i (enqueue), pop_i (dequeue),
//        head_o (oldest tag), full_o, empty_o. Push when full and pop when empty are ignored.
module resp_tag_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  resp_tag_t tag_i,
    output resp_tag_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    resp_tag_t     mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    // explicit wrap keeps DEPTH=1 (single-slot pointer) correct
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];

    always_comb begin
        wr_d  = do_push ? nxt(wr_q) : wr_q;
        rd_d  = do_pop ? nxt(rd_q) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
        if (do_push) mem_q[wr_q] <= tag_i;
    end

endmodule

// File: rtl/sram_d_arbiter.sv
// sram_d_arbiter: round-robin OBI arbiter of two data managers onto the single SRAM data port
// Ports: clk_i, rst_i (sync, active-high);
//        m0_*/m1_*: OBI manager request (req/addr/we/be/wdata), gnt, rvalid/rdata;
//        s_*: subordinate OBI port to the SRAM (req/gnt/addr/we/be/wdata/rvalid/rdata);
//        resp_err_o: registered one-cycle pulse on an unexpected SRAM response.
module sram_d_arbiter
    import sram_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int WRITE_RESP      = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m1_req_i,
    output logic        m0_gnt_o,
    output logic        m1_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m1_addr_i,
    input  logic        m0_we_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m0_wdata_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m0_rvalid_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic [31:0] m1_rdata_o,
    output logic        s_req_o,
    input  logic        s_gnt_i,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    output logic        resp_err_o
);

    logic        prio_q, prio_d, err_q, err_d;
    logic        sel, accept, full, empty, synth, pop;
    logic [31:0] rsp_data;
    resp_tag_t   head, push_tag;

    always_comb begin
        sel         = (m0_req_i && m1_req_i) ? prio_q : (m1_req_i ? MGR1 : MGR0);
        s_req_o     = (m0_req_i || m1_req_i) && !rst_i && !full;
        accept      = s_req_o && s_gnt_i;
        s_addr_o    = sel ? m1_addr_i : m0_addr_i;
        s_we_o      = sel ? m1_we_i : m0_we_i;
        s_be_o      = sel ? m1_be_i : m0_be_i;
        s_wdata_o   = sel ? m1_wdata_i : m0_wdata_i;
        m0_gnt_o    = accept && sel == MGR0;
        m1_gnt_o    = accept && sel == MGR1;
        prio_d      = accept ? !sel : prio_q;
        push_tag    = '{id: sel, we: s_we_o};
        // write at the head retires on its own when the SRAM gives no write response
        synth       = WRITE_RESP == 0 && !empty && head.we;
        pop         = !rst_i && (synth || (s_rvalid_i && !empty));
        rsp_data    = synth ? '0 : s_rdata_i;
        m0_rvalid_o = pop && head.id == MGR0;
        m1_rvalid_o = pop && head.id == MGR1;
        m0_rdata_o  = m0_rvalid_o ? rsp_data : '0;
        m1_rdata_o  = m1_rvalid_o ? rsp_data : '0;
        // SRAM response with nothing to match, or colliding with a synthesized write
        err_d       = !rst_i && s_rvalid_i && (empty || synth);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= MGR0;
            err_q  <= 1'b0;
        end else begin
            prio_q <= prio_d;
            err_q  <= err_d;
        end
    end

    assign resp_err_o = err_q;

    resp_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .pop_i   (pop),
        .tag_i   (push_tag),
        .head_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule

// File: tb/tb_sram_d_arbiter.sv
// tb_sram_d_arbiter: directed bench with an SRAM model and an in-order response scoreboard
module tb_sram_d_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_i, m1_req_i, m0_gnt_o, m1_gnt_o;
    logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
    logic        m0_we_i, m1_we_i;
    logic [3:0]  m0_be_i, m1_be_i;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i, resp_err_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [3:0]  s_be_o;

    always #5 clk_i = ~clk_i;

    sram_d_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m1_req_i(m1_req_i), .m0_gnt_o(m0_gnt_o), .m1_gnt_o(m1_gnt_o),
        .m0_addr_i(m0_addr_i), .m1_addr_i(m1_addr_i), .m0_we_i(m0_we_i), .m1_we_i(m1_we_i),
        .m0_be_i(m0_be_i), .m1_be_i(m1_be_i), .m0_wdata_i(m0_wdata_i), .m1_wdata_i(m1_wdata_i),
        .m0_rvalid_o(m0_rvalid_o), .m1_rvalid_o(m1_rvalid_o),
        .m0_rdata_o(m0_rdata_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
        .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
        .resp_err_o(resp_err_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        for (int b = 0; b < 4; b++) if (be[b]) o[8*b +: 8] = n[8*b +: 8];
        return o;
    endfunction

    logic [31:0] sram_mem [64];
    logic [31:0] ref_mem  [64];
    logic [31:0] pend [$];
    logic        hold = 1'b0;
    logic        spur = 1'b0;
    logic        mh, ms;

    // SRAM model: 1-cycle read latency, no write responses, hold withholds rvalid
    initial begin
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        forever begin
            @(negedge clk_i);
            mh = hold;
            ms = spur;
            if (s_req_o && s_gnt_i) begin
                if (s_we_o) sram_mem[s_addr_o[7:2]] = merge(sram_mem[s_addr_o[7:2]], s_wdata_o, s_be_o);
                else pend.push_back(sram_mem[s_addr_o[7:2]]);
            end
            @(posedge clk_i);
            #1;
            if (ms) begin
                s_rvalid_i = 1'b1;
                s_rdata_i  = 32'hDEAD_0000;
            end else if (!mh && pend.size() > 0) begin
                s_rvalid_i = 1'b1;
                s_rdata_i  = pend.pop_front();
            end else begin
                s_rvalid_i = 1'b0;
                s_rdata_i  = '0;
            end
        end
    end

    typedef struct {
        logic        id;
        logic [31:0] data;
    } exp_t;
    exp_t        sb [$];
    exp_t        e;
    logic        gid;
    logic [31:0] gaddr;

    // scoreboard: expectation pushed at grant, checked when a manager rvalid appears
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) sb.delete();
            else begin
                if (m0_rvalid_o || m1_rvalid_o) begin
                    if (sb.size() == 0) chk("rsp_unexpected", 32'({m1_rvalid_o, m0_rvalid_o}), 32'd0);
                    else begin
                        e = sb.pop_front();
                        chk("rsp_mgr", 32'({m1_rvalid_o, m0_rvalid_o}), e.id ? 32'd2 : 32'd1);
                        chk("rsp_data", e.id ? m1_rdata_o : m0_rdata_o, e.data);
                        chk("rsp_other_rdata", e.id ? m0_rdata_o : m1_rdata_o, 32'd0);
                    end
                end
                if (m0_gnt_o || m1_gnt_o) begin
                    gid   = m1_gnt_o;
                    gaddr = gid ? m1_addr_i : m0_addr_i;
                    chk("s_addr", s_addr_o, gaddr);
                    if (gid ? m1_we_i : m0_we_i) begin
                        ref_mem[gaddr[7:2]] = merge(ref_mem[gaddr[7:2]], gid ? m1_wdata_i : m0_wdata_i, gid ? m1_be_i : m0_be_i);
                        sb.push_back('{id: gid, data: 32'd0});
                    end else sb.push_back('{id: gid, data: ref_mem[gaddr[7:2]]});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic neg();
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        m0_req_i = 1'b0;
        m1_req_i = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        sram_mem[0] = 32'h1111_1111; ref_mem[0] = 32'h1111_1111;
        sram_mem[1] = 32'h2222_2222; ref_mem[1] = 32'h2222_2222;
        sram_mem[2] = 32'h3333_3333; ref_mem[2] = 32'h3333_3333;
        rst_i = 1'b1; s_gnt_i = 1'b1;
        m0_req_i = 1'b1; m1_req_i = 1'b0;
        m0_addr_i = 32'h8000_0000; m1_addr_i = 32'h8000_0004;
        m0_we_i = 1'b0; m1_we_i = 1'b0; m0_be_i = 4'hF; m1_be_i = 4'hF;
        m0_wdata_i = '0; m1_wdata_i = '0;
        // reset gating
        cyc(); neg();
        chk("rst_s_req", 32'(s_req_o), 32'd0);
        chk("rst_gnt0", 32'(m0_gnt_o), 32'd0);
        chk("rst_err", 32'(resp_err_o), 32'd0);
        cyc(); rst_i = 1'b0; m0_req_i = 1'b0;
        // alternating load
        cyc(); m0_req_i = 1'b1; m1_req_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            neg();
            chk("alt_gnt0", 32'(m0_gnt_o), 32'(i % 2 == 0));
            chk("alt_gnt1", 32'(m1_gnt_o), 32'(i % 2 == 1));
            cyc();
        end
        idle(3);
        // single requester, then prio must point back at m0
        m1_req_i = 1'b1; m1_addr_i = 32'h8000_0008;
        for (int i = 0; i < 4; i++) begin
            neg();
            chk("single_gnt1", 32'(m1_gnt_o), 32'd1);
            chk("single_gnt0", 32'(m0_gnt_o), 32'd0);
            cyc();
        end
        m0_req_i = 1'b1;
        neg(); chk("single_prio_gnt0", 32'(m0_gnt_o), 32'd1);
        cyc();
        neg(); chk("single_prio_gnt1", 32'(m1_gnt_o), 32'd1);
        cyc(); idle(3);
        // synthesized write response then read-back
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_addr_i = 32'h8000_0010;
        m0_wdata_i = 32'hCAFE_BABE; m0_be_i = 4'b0011;
        neg();
        chk("wr_gnt0", 32'(m0_gnt_o), 32'd1);
        chk("wr_s_we", 32'(s_we_o), 32'd1);
        chk("wr_s_be", 32'(s_be_o), 32'h3);
        chk("wr_s_wdata", s_wdata_o, 32'hCAFE_BABE);
        cyc(); m0_we_i = 1'b0; m0_be_i = 4'hF;
        neg();
        chk("wr_rvalid", 32'(m0_rvalid_o), 32'd1);
        chk("wr_rdata", m0_rdata_o, 32'd0);
        chk("wr_m1_rvalid", 32'(m1_rvalid_o), 32'd0);
        chk("rd_gnt0", 32'(m0_gnt_o), 32'd1);
        cyc(); m0_req_i = 1'b0;
        neg();
        chk("rd_rvalid", 32'(m0_rvalid_o), 32'd1);
        chk("rd_rdata", m0_rdata_o, 32'h0000_BABE);
        idle(3);
        // full FIFO: responses withheld three cycles
        hold = 1'b1; m0_req_i = 1'b1; m0_addr_i = 32'h8000_0000;
        neg(); chk("full_c1_sreq", 32'(s_req_o), 32'd1); chk("full_c1_gnt0", 32'(m0_gnt_o), 32'd1);
        cyc(); neg(); chk("full_c2_sreq", 32'(s_req_o), 32'd1);
        cyc(); neg(); chk("full_c3_sreq", 32'(s_req_o), 32'd0); chk("full_c3_gnt0", 32'(m0_gnt_o), 32'd0);
        cyc(); hold = 1'b0;
        neg(); chk("full_c4_sreq", 32'(s_req_o), 32'd0); chk("full_c4_rvalid", 32'(m0_rvalid_o), 32'd0);
        cyc(); neg(); chk("full_c5_rvalid", 32'(m0_rvalid_o), 32'd1); chk("full_c5_sreq", 32'(s_req_o), 32'd0);
        cyc(); neg(); chk("full_c6_sreq", 32'(s_req_o), 32'd1); chk("full_c6_gnt0", 32'(m0_gnt_o), 32'd1);
        cyc(); idle(4);
        // spurious response
        spur = 1'b1;
        cyc(); spur = 1'b0;
        neg();
        chk("spur_m0_rvalid", 32'(m0_rvalid_o), 32'd0);
        chk("spur_m1_rvalid", 32'(m1_rvalid_o), 32'd0);
        chk("spur_err_early", 32'(resp_err_o), 32'd0);
        cyc(); neg(); chk("spur_err", 32'(resp_err_o), 32'd1);
        cyc(); neg(); chk("spur_err_clear", 32'(resp_err_o), 32'd0);
        cyc();
        // reset with two reads in flight; stale SRAM responses must only flag resp_err_o
        hold = 1'b1; m0_req_i = 1'b1; m1_req_i = 1'b1; m0_addr_i = 32'h8000_0000; m1_addr_i = 32'h8000_0004;
        neg(); chk("rif_c1_sreq", 32'(s_req_o), 32'd1); chk("rif_c1_gnt", 32'(m0_gnt_o || m1_gnt_o), 32'd1);
        cyc(); neg(); chk("rif_c2_sreq", 32'(s_req_o), 32'd1);
        cyc(); rst_i = 1'b1; m1_req_i = 1'b0;
        neg(); chk("rif_rst_sreq", 32'(s_req_o), 32'd0); chk("rif_rst_gnt0", 32'(m0_gnt_o), 32'd0);
        cyc(); rst_i = 1'b0; hold = 1'b0; m0_req_i = 1'b0;
        neg(); chk("rif_c4_err", 32'(resp_err_o), 32'd0);
        cyc(); neg();
        chk("rif_c5_m0_rvalid", 32'(m0_rvalid_o), 32'd0);
        chk("rif_c5_m1_rvalid", 32'(m1_rvalid_o), 32'd0);
        chk("rif_c5_err", 32'(resp_err_o), 32'd0);
        cyc(); neg();
        chk("rif_c6_m0_rvalid", 32'(m0_rvalid_o), 32'd0);
        chk("rif_c6_m1_rvalid", 32'(m1_rvalid_o), 32'd0);
        chk("rif_c6_err", 32'(resp_err_o), 32'd1);
        cyc(); neg(); chk("rif_c7_err", 32'(resp_err_o), 32'd1);
        cyc(); neg(); chk("rif_c8_err", 32'(resp_err_o), 32'd0);
        cyc(); m0_req_i = 1'b1; m1_req_i = 1'b1;
        neg(); chk("rif_prio_gnt0", 32'(m0_gnt_o), 32'd1);
        cyc(); neg(); chk("rif_prio_gnt1", 32'(m1_gnt_o), 32'd1);
        cyc(); idle(4);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sram_d_arbiter.md
# sram_d_arbiter

Two-manager OBI arbiter for the SoC's single SRAM data port. Manager 0 is the core data (LSU) port; manager 1 is the secondary data master (DMA/debug). The arbiter grants round-robin, muxes the request onto the one subordinate port that feeds the SRAM `sram_d_*` interface, and steers in-order responses back to the originating manager. It synthesizes write responses, because the SRAM raises `rvalid` only for reads.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: depth of the response-tracking FIFO; power of two, ≥1.
- `WRITE_RESP`, default 0: 0 = arbiter generates write responses; 1 = subordinate returns `rvalid` for writes.

Ports (clock and reset first):
- `clk_i` input 1: the block's only clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `m0_req_i`, `m1_req_i` input 1: OBI request.
- `m0_gnt_o`, `m1_gnt_o` output 1: OBI grant.
- `m0_addr_i`, `m1_addr_i` input 32: byte address.
- `m0_we_i`, `m1_we_i` input 1: write enable.
- `m0_be_i`, `m1_be_i` input 4: byte enables.
- `m0_wdata_i`, `m1_wdata_i` input 32: write data.
- `m0_rvalid_o`, `m1_rvalid_o` output 1: response valid.
- `m0_rdata_o`, `m1_rdata_o` output 32: response data.
- `s_req_o` output 1: request to the SRAM data port.
- `s_gnt_i` input 1: grant from the SRAM.
- `s_addr_o` output 32: muxed address.
- `s_we_o` output 1: muxed write enable.
- `s_be_o` output 4: muxed byte enables.
- `s_wdata_o` output 32: muxed write data.
- `s_rvalid_i` input 1: SRAM response valid.
- `s_rdata_i` input 32: SRAM response data.
- `resp_err_o` output 1: registered one-cycle pulse on a response protocol violation.

## Operation
- **Priority pointer** `prio`, 1 bit, reset 0, so manager 0 is favoured first.
  - Both managers requesting: the `prio` manager is selected.
  - One requesting: that manager is selected.
- **Request acceptance** (`accept`) happens when `s_req_o && s_gnt_i`.
  - On accept, `prio` is set to the non-selected manager index.
  - With no accept, `prio` holds.
- **Subordinate request**
  - `s_req_o` = (any request) && !fifo_full.
  - Address, attribute and wdata muxes are combinational from the selected manager.
  - Unselected muxes drive the manager 0 values. They are don't-care when `s_req_o`=0.
- **Grant**
  - `mX_gnt_o` = selected==X && `s_req_o` && `s_gnt_i`.
  - A non-selected manager never sees `gnt`.
  - Managers must hold `req` and attributes until `gnt` (OBI). The arbiter does not re-arbitrate a held request differently, except by round-robin order.
- **Response tracking FIFO** holds one tag per accepted transaction: {id (1 bit), we (1 bit)}.
  - A tag is pushed on accept.
  - If `WRITE_RESP`=0 and the head tag is a write: the entry pops that cycle and the arbiter drives `m[id]_rvalid_o`=1 with rdata=0.
  - If the head tag is a read, or `WRITE_RESP`=1: a pop occurs on `s_rvalid_i`, driving `m[id]_rvalid_o`=1 and `m[id]_rdata_o`=`s_rdata_i`.
  - A non-responding manager's rdata is 0.
- **Full FIFO**
  - No accept while full, even if a pop occurs that cycle. This rule is fixed and simplifies timing.
  - Simultaneous push and pop when not full is legal: count is unchanged and pointers wrap modulo `MAX_OUTSTANDING`.
- **Protocol errors**
  - `s_rvalid_i` with the FIFO empty sets `resp_err_o`=1 next cycle. No pop occurs and no manager `rvalid` is driven.
  - `s_rvalid_i` while the head is a synthesized write (`WRITE_RESP`=0) also sets `resp_err_o`. The write retires, and the read data is dropped.

## Timing
- The grant path is combinational: request to `gnt` in the same cycle, zero added latency.
- Synthesized write responses appear no earlier than the cycle after accept, i.e. once the tag is at the FIFO head.
- Read responses are combinational pass-through of `s_rvalid_i` and `s_rdata_i`, so SRAM read latency (1 cycle) is preserved.
- Reset values:
  - FIFO empty; `prio`=0; `resp_err_o`=0.
  - All `gnt`, `rvalid` and `s_req_o` outputs are 0 during the reset cycle: requests are gated by `!rst_i`.
- Reset mid-operation discards in-flight tags. Any SRAM `rvalid` arriving after reset flags `resp_err_o`.

## Structure
- Package `sram_arb_pkg` holds:
  - typedef `resp_tag_t` {logic id; logic we};
  - localparams `MGR0`=0 and `MGR1`=1.
- Sub-module `resp_tag_fifo`: a synchronous FIFO of `resp_tag_t` with push, pop, full, empty and head.
- Arbitration, muxing and steering live in the top module.

## Test plan
- **Alternating load.** Stimulus: both managers request reads continuously; m0 reads 0x8000_0000, m1 reads 0x8000_0004. Required: grants alternate m0, m1, m0…; each `rvalid` goes to the correct manager with that word's data.
- **Single requester.** Stimulus: m1 alone issues 4 back-to-back reads. Required: `gnt` every cycle, four `rvalid` pulses one cycle later, `prio` toggles to 0 after each accept.
- **Synthesized write response.** Stimulus: m0 writes 0xCAFEBABE with be=4'b0011, then reads the same address. Required: m0 `rvalid` with rdata=0 the cycle after the write accept; the read returns 0x0000BABE over an initial-zero word.
- **Full FIFO.** Stimulus: `MAX_OUTSTANDING`=2, `s_gnt_i`=1, SRAM withholds `rvalid` for 3 cycles. Required: `s_req_o` drops after 2 accepts and resumes the cycle after the first pop.
- **Spurious response.** Stimulus: `s_rvalid_i`=1 with no outstanding request. Required: `resp_err_o` pulses high for exactly one cycle; no manager `rvalid`.
- **Reset with reads in flight.** Stimulus: assert `rst_i` with 2 reads outstanding. Required: FIFO empty, `prio`=0, no stale `rvalid` to either manager after reset deasserts.
